// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding, grant ids
// and the "no write" byte-enable value.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   localparam logic [3:0] WSTRB_NONE = 4'b0;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: with both requesting, the one that
// did not win last time is chosen; otherwise the lone requester wins.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_any,
   output logic grant_id
);

   assign grant_any = req0 | req1;
   assign grant_id  = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and data access,
// one transaction at a time, with a watchdog that aborts unanswered grants.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int TCW     = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        err_clear,
   output logic        timeout_err
);

   localparam logic [TCW-1:0] CNT_LAST = (TIMEOUT > 0) ? TCW'(TIMEOUT - 1) : '0;

   arb_state_t     state_reg, state_next;
   logic           last_grant_reg, last_grant_next;
   logic [TCW-1:0] cnt_reg, cnt_next;
   logic           err_reg, err_next;

   logic grant_any, grant_id;
   logic owner_valid, expire, timeout_set;

   rr_arb2 u_rr_arb2 (
      .req0       (i_valid),
      .req1       (d_valid),
      .last_grant (last_grant_reg),
      .grant_any  (grant_any),
      .grant_id   (grant_id)
   );

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      cnt_next        = cnt_reg;
      timeout_set     = 1'b0;
      owner_valid     = (state_reg == GNT_I) ? i_valid : d_valid;
      expire          = (TIMEOUT > 0) && (cnt_reg == CNT_LAST) && !mem_ready;

      case (state_reg)
         IDLE: begin
            if (grant_any) begin
               state_next      = (grant_id == GRANT_I) ? GNT_I : GNT_D;
               last_grant_next = grant_id;
               cnt_next        = '0;
            end
         end
         GNT_I, GNT_D: begin
            // Withdraw takes priority; completion beats a simultaneous expiry.
            if (!owner_valid || mem_ready) begin
               state_next = IDLE;
            end else if (expire) begin
               state_next  = IDLE;
               timeout_set = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      err_next = timeout_set | (err_reg & ~err_clear);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= GRANT_D;
         cnt_reg        <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         cnt_reg        <= cnt_next;
         err_reg        <= err_next;
      end
   end

   // Outputs decode from the registered state; a withdrawn requester gets no ready.
   assign mem_valid   = (state_reg == GNT_I) || (state_reg == GNT_D);
   assign i_ready     = (state_reg == GNT_I) && i_valid && mem_ready;
   assign d_ready     = (state_reg == GNT_D) && d_valid && mem_ready;
   assign i_rdata     = mem_rdata;
   assign d_rdata     = mem_rdata;
   assign timeout_err = err_reg;

   assign mem_addr  = (state_reg == GNT_D) ? d_addr :
                      (state_reg == GNT_I) ? i_addr : 32'd0;
   assign mem_wdata = (state_reg == GNT_D) ? d_wdata : 32'd0;
   assign mem_wstrb = (state_reg == GNT_D) ? d_wstrb : WSTRB_NONE;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// timeout/withdraw/reset sequences, and randomized traffic against a model.
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_ready;
   logic [31:0] i_addr, i_rdata;
   logic        d_valid, d_ready;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        err_clear, timeout_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TO), .TCW(3)) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .err_clear(err_clear), .timeout_err(timeout_err)
   );

   typedef struct {
      logic        iv, dv, mr;
      logic [31:0] rd;
      logic        e_mv, e_ir, e_dr;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_ws;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic iv, dv, mr, input logic [31:0] rd,
                               input logic mv, ir, dr, input logic [31:0] a, wd,
                               input logic [3:0] ws);
      vec_t v;
      v.iv = iv; v.dv = dv; v.mr = mr; v.rd = rd;
      v.e_mv = mv; v.e_ir = ir; v.e_dr = dr; v.e_addr = a; v.e_wd = wd; v.e_ws = ws;
      return v;
   endfunction

   // Checks the outputs common to every hand-written step.
   task automatic step_chk(input string tag, input logic mv, ir, dr, err);
      @(negedge clk);
      chk({tag, "_mem_valid"}, 32'(mem_valid), 32'(mv));
      chk({tag, "_i_ready"}, 32'(i_ready), 32'(ir));
      chk({tag, "_d_ready"}, 32'(d_ready), 32'(dr));
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(err));
   endtask

   // Reference model state, kept at transaction level.
   int   owner;      // 0 nobody, 1 fetch, 2 data
   int   waited;
   int   last_won;   // 1 fetch, 2 data
   logic m_err;
   logic ip, dp;

   initial begin
      rst = 1'b1; i_valid = 0; d_valid = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
      d_wstrb = 0; mem_ready = 0; mem_rdata = 0; err_clear = 0;
      tick();
      @(negedge clk);
      chk("reset_mem_valid", 32'(mem_valid), 32'd0);
      chk("reset_i_ready", 32'(i_ready), 32'd0);
      chk("reset_d_ready", 32'(d_ready), 32'd0);
      chk("reset_timeout_err", 32'(timeout_err), 32'd0);
      tick();
      rst = 1'b0;

      // Directed table: fetch with wait states, store, alternation under contention.
      vecs[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[1]  = mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h100,  32'h0,        4'h0);
      vecs[2]  = mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h100,  32'h0,        4'h0);
      vecs[3]  = mk(1, 0, 1, 32'hDEADBEEF, 1, 1, 0, 32'h100,  32'h0,        4'h0);
      vecs[4]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[5]  = mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[6]  = mk(0, 1, 1, 32'hCAFEF00D, 1, 0, 1, 32'h2000, 32'h12345678, 4'b0011);
      vecs[7]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[8]  = mk(1, 1, 1, 32'h11111111, 0, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[9]  = mk(1, 1, 1, 32'h22222222, 1, 1, 0, 32'h100,  32'h0,        4'h0);
      vecs[10] = mk(1, 1, 1, 32'h33333333, 0, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[11] = mk(1, 1, 1, 32'h44444444, 1, 0, 1, 32'h2000, 32'h12345678, 4'b0011);
      vecs[12] = mk(1, 1, 1, 32'h55555555, 0, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[13] = mk(1, 1, 1, 32'h66666666, 1, 1, 0, 32'h100,  32'h0,        4'h0);
      vecs[14] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0);

      i_addr = 32'h100; d_addr = 32'h2000; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
      for (int r = 0; r < 15; r++) begin
         i_valid = vecs[r].iv; d_valid = vecs[r].dv;
         mem_ready = vecs[r].mr; mem_rdata = vecs[r].rd;
         @(negedge clk);
         chk($sformatf("vec%0d_mem_valid", r), 32'(mem_valid), 32'(vecs[r].e_mv));
         chk($sformatf("vec%0d_i_ready", r), 32'(i_ready), 32'(vecs[r].e_ir));
         chk($sformatf("vec%0d_d_ready", r), 32'(d_ready), 32'(vecs[r].e_dr));
         chk($sformatf("vec%0d_i_rdata", r), i_rdata, vecs[r].rd);
         chk($sformatf("vec%0d_d_rdata", r), d_rdata, vecs[r].rd);
         if (vecs[r].e_mv) begin
            chk($sformatf("vec%0d_mem_addr", r), mem_addr, vecs[r].e_addr);
            chk($sformatf("vec%0d_mem_wdata", r), mem_wdata, vecs[r].e_wd);
            chk($sformatf("vec%0d_mem_wstrb", r), 32'(mem_wstrb), 32'(vecs[r].e_ws));
         end
         $display("vec %0d: mem_valid=%0b i_ready=%0b d_ready=%0b addr=0x%08h",
                  r, mem_valid, i_ready, d_ready, mem_addr);
         tick();
      end

      // Watchdog: four unanswered cycles, bubble, re-grant, withdraw, clear.
      i_valid = 1; i_addr = 32'h300; d_valid = 0; mem_ready = 0;
      step_chk("to_idle", 0, 0, 0, 0); tick();
      for (int k = 0; k < TO; k++) begin
         step_chk($sformatf("to_wait%0d", k), 1, 0, 0, 0); tick();
      end
      step_chk("to_bubble", 0, 0, 0, 1); tick();
      i_valid = 0;
      step_chk("to_regrant", 1, 0, 0, 1); tick();
      err_clear = 1;
      step_chk("to_held", 0, 0, 0, 1); tick();
      err_clear = 0;
      step_chk("to_cleared", 0, 0, 0, 0); tick();
      $display("timeout sequence done: timeout_err=%0b", timeout_err);

      // Data withdraws mid-grant; pending fetch takes the port next.
      i_valid = 1; i_addr = 32'h400; d_valid = 1; d_addr = 32'h500; d_wstrb = 0;
      step_chk("wd_idle", 0, 0, 0, 0); tick();
      step_chk("wd_gnt_d", 1, 0, 0, 0);
      chk("wd_gnt_d_addr", mem_addr, 32'h500); tick();
      d_valid = 0;
      step_chk("wd_drop", 1, 0, 0, 0); tick();
      step_chk("wd_release", 0, 0, 0, 0); tick();
      mem_ready = 1; mem_rdata = 32'hA5A5A5A5;
      step_chk("wd_gnt_i", 1, 1, 0, 0);
      chk("wd_gnt_i_addr", mem_addr, 32'h400); tick();
      i_valid = 0; mem_ready = 0;
      step_chk("wd_done", 0, 0, 0, 0); tick();
      $display("withdraw sequence done");

      // Reset during a grant with mem_ready high: everything back to reset values.
      i_valid = 1; i_addr = 32'h600;
      step_chk("rs_idle", 0, 0, 0, 0); tick();
      for (int k = 0; k < TO; k++) begin
         step_chk($sformatf("rs_wait%0d", k), 1, 0, 0, 0); tick();
      end
      step_chk("rs_bubble", 0, 0, 0, 1); tick();
      rst = 1; mem_ready = 1;
      @(negedge clk);
      chk("rs_in_grant", 32'(mem_valid), 32'd1);
      tick();
      rst = 0; mem_ready = 0; i_valid = 1; d_valid = 1; d_addr = 32'h700;
      step_chk("rs_after", 0, 0, 0, 0); tick();
      step_chk("rs_first_gnt", 1, 0, 0, 0);
      chk("rs_first_gnt_addr", mem_addr, 32'h600);
      tick();
      i_valid = 0; d_valid = 0;
      $display("reset sequence done");

      // Randomized traffic against the transaction-level model.
      rst = 1; tick(); rst = 0;
      owner = 0; waited = 0; last_won = 2; m_err = 0; ip = 0; dp = 0;
      for (int c = 0; c < 400; c++) begin
         logic        e_ir, e_dr, expired, gv;
         logic [31:0] e_addr;
         if (!ip && ($urandom % 3 == 0)) begin ip = 1; i_addr = $urandom; end
         if (!dp && ($urandom % 3 == 0)) begin
            dp = 1; d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
         end
         i_valid = ip; d_valid = dp;
         mem_ready = ($urandom % 5) < 2;
         mem_rdata = $urandom;
         err_clear = ($urandom % 10) == 0;

         gv     = (owner == 1) ? ip : (owner == 2) ? dp : 1'b0;
         e_ir   = (owner == 1) && ip && mem_ready;
         e_dr   = (owner == 2) && dp && mem_ready;
         e_addr = (owner == 1) ? i_addr : d_addr;
         @(negedge clk);
         chk($sformatf("rnd%0d_mem_valid", c), 32'(mem_valid), 32'(owner != 0));
         chk($sformatf("rnd%0d_i_ready", c), 32'(i_ready), 32'(e_ir));
         chk($sformatf("rnd%0d_d_ready", c), 32'(d_ready), 32'(e_dr));
         chk($sformatf("rnd%0d_timeout_err", c), 32'(timeout_err), 32'(m_err));
         if (owner != 0) begin
            chk($sformatf("rnd%0d_mem_addr", c), mem_addr, e_addr);
            chk($sformatf("rnd%0d_mem_wstrb", c), 32'(mem_wstrb),
                (owner == 2) ? 32'(d_wstrb) : 32'd0);
         end
         if (e_ir || e_dr)
            $display("rnd %0d: %s done addr=0x%08h", c, e_ir ? "fetch" : "data", e_addr);

         expired = 0;
         if (owner == 0) begin
            if (ip || dp) begin
               owner  = (ip && dp) ? ((last_won == 2) ? 1 : 2) : (ip ? 1 : 2);
               last_won = owner;
               waited = 0;
            end
         end else if (!gv || mem_ready) begin
            owner = 0;
         end else if (waited == TO - 1) begin
            owner = 0; expired = 1;
         end else begin
            waited++;
         end
         if (expired) m_err = 1;
         else if (err_clear) m_err = 0;
         if (e_ir) ip = 0;
         if (e_dr) dp = 0;
         tick();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
